mem_responder: RTL and testbench
================================

# mem_responder

Byte-wide memory target that serves the multicycle CPU's fetch, load-byte and store-byte accesses over a valid/ready request and one-shot response handshake. It holds the unified instruction/data storage, inserts a programmable number of wait states, and executes exactly one access at a time. It sits between the controller/datapath address mux and the memory array, replacing the zero-latency combinational memory model.

## Interface
- WIDTH, 8: data width in bits.
- ADDR_WIDTH, 8: address width; storage depth is 2^ADDR_WIDTH bytes.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and response; 0 is legal.
- PROTECT_LIMIT, 8'h40: writes to addresses below this value are protected (used only with the configuration macro).

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_write  in  1  1 = store byte, 0 = read (fetch or load).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  WIDTH  store data.
- req_ready  out  1  block can accept a request; high only in IDLE.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  WIDTH  read data; 0 for writes.
- rsp_err  out  1  protected-write error, qualified by rsp_valid.
- busy  out  1  high in WAIT or RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, latch addr, write and wdata. Go to WAIT if WAIT_CYCLES > 0, otherwise go to RESP.
- WAIT: the wait counter loads WAIT_CYCLES-1 on accept and decrements each cycle. At 0, go to RESP.
- Entering RESP (same edge):
  - Reads load rsp_rdata from the array at the latched address.
  - Writes commit to the array and load rsp_rdata with 0.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE unconditionally. There is no response backpressure.
- req_valid outside IDLE is ignored. The requester must hold the request until it sees req_ready && req_valid.
- Only one access is outstanding. A read following a write to the same address returns the new data.
- Counter width is $clog2(WAIT_CYCLES+1), with a minimum of 1. Addresses use the full ADDR_WIDTH, so no wrap or range check is needed.
- Reset at any point:
  - State goes to IDLE; rsp_valid, rsp_err, rsp_rdata and busy go to 0; req_ready = 1.
  - A pending write still in WAIT is discarded and never committed.
  - Storage contents are not reset.

## Timing
- Accept on edge N. rsp_valid is high in cycle N+1+WAIT_CYCLES.
- req_ready is high again in cycle N+2+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- rsp_rdata is registered and holds its value until the next RESP entry.
- rsp_err is registered and is high only during the RESP cycle.
- req_ready and busy are decoded from state registers only; there is no combinational input-to-output path.

## Configuration
- MEM_RESPONDER_PROTECT_EN defined:
  - A write with addr < PROTECT_LIMIT is not committed.
  - rsp_err = 1 during its RESP cycle; rsp_rdata = 0.
  - Reads never error.
- Undefined: all writes commit and rsp_err is tied to 0.

## Structure
- Shared package mem_pkg holds:
  - state encodings IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - default WIDTH and ADDR_WIDTH;
  - PROTECT_LIMIT default.
- One sub-module, mem_array: 2^ADDR_WIDTH x WIDTH storage with synchronous write enable and combinational read port, and no reset.
- FSM, wait counter, request latches and the protect check live in mem_responder.

## Test plan
- WAIT_CYCLES=2; write 8'hA5 to 8'h80, then read 8'h80.
  - rsp_valid is high 3 cycles after each accept.
  - Read returns rsp_rdata = 8'hA5 and rsp_err = 0.
- WAIT_CYCLES=0; back-to-back reads with req_valid held high.
  - rsp_valid is high the cycle after accept.
  - Accepts occur every 2 cycles.
- Macro on; write 8'h3C to 8'h10, then read 8'h10.
  - Write response has rsp_err = 1.
  - Read returns the pre-existing value.
- Macro off; same stimulus.
  - rsp_err = 0.
  - Read returns 8'h3C.
- Assert reset during WAIT of a write of 8'hFF to 8'h90, then read 8'h90.
  - Old value is returned, not 8'hFF.
  - Outputs are 0 and req_ready = 1 immediately on reset.
- Change req_addr and req_write while busy.
  - Response reflects the latched request only.
  - No extra rsp_valid pulse occurs.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory responder: FSM encodings and
// default geometry / protection limit.
package mem_pkg;

    localparam int MEM_WIDTH      = 8;
    localparam int MEM_ADDR_WIDTH = 8;

    localparam logic [7:0] MEM_PROTECT_LIMIT = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Unified instruction/data storage: synchronous write, combinational read,
// contents deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

    // Byte write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory target with valid/ready request and one-shot response.
// Optional write protection below PROTECT_LIMIT: MEM_RESPONDER_PROTECT_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                    WIDTH         = MEM_WIDTH,
    parameter int                    ADDR_WIDTH    = MEM_ADDR_WIDTH,
    parameter int                    WAIT_CYCLES   = 2,
    parameter logic [ADDR_WIDTH-1:0] PROTECT_LIMIT = ADDR_WIDTH'(MEM_PROTECT_LIMIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : CNT_W'(0);

`ifdef MEM_RESPONDER_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    state_t                state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic                  accept_s;
    logic                  enter_resp_s;

    logic                  write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [WIDTH-1:0]      wdata_r;

    logic                  acc_write_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [WIDTH-1:0]      acc_wdata_s;
    logic                  prot_s;
    logic                  we_s;
    logic [WIDTH-1:0]      arr_rdata_s;

    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [WIDTH-1:0]      rsp_rdata_r;

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = CNT_LOAD;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s  = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_W'(0)) begin
                    state_nxt_s  = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the access executes on the accept edge, so the
    // live request is used instead of the not-yet-loaded latches.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_write_s = req_write;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
        end else begin
            acc_write_s = write_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign prot_s = PROTECT_EN && acc_write_s && (acc_addr_s < PROTECT_LIMIT);
    assign we_s   = enter_resp_s && acc_write_s && !prot_s && !reset;

    mem_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (acc_addr_s),
        .wdata (acc_wdata_s),
        .rdata (arr_rdata_s)
    );

    // FSM state and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latches, loaded only on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (accept_s) begin
            write_r <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // Response registers: strobe and error live for the RESP cycle only,
    // read data holds until the next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= enter_resp_s;
            rsp_err_r   <= enter_resp_s && prot_s;
            if (enter_resp_s) begin
                rsp_rdata_r <= acc_write_s ? WIDTH'(0) : arr_rdata_s;
            end
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_WAIT) || (state_r == ST_RESP);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance 0 uses two wait states,
// instance 1 uses none; expected values are hand-computed.
module tb_mem_responder;
    import mem_pkg::*;

`ifdef MEM_RESPONDER_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] rv, rw, rdy, rspv, err, bsy;
    logic [7:0] ra [2];
    logic [7:0] wd [2];
    logic [7:0] rd [2];

    int n_checks;
    int n_fail;

    mem_responder #(
        .WIDTH (8), .ADDR_WIDTH (8), .WAIT_CYCLES (2), .PROTECT_LIMIT (8'h40)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid (rv[0]), .req_write (rw[0]), .req_addr (ra[0]), .req_wdata (wd[0]),
        .req_ready (rdy[0]), .rsp_valid (rspv[0]), .rsp_rdata (rd[0]),
        .rsp_err (err[0]), .busy (bsy[0])
    );

    mem_responder #(
        .WIDTH (8), .ADDR_WIDTH (8), .WAIT_CYCLES (0), .PROTECT_LIMIT (8'h40)
    ) dut0 (
        .clk (clk), .reset (reset),
        .req_valid (rv[1]), .req_write (rw[1]), .req_addr (ra[1]), .req_wdata (wd[1]),
        .req_ready (rdy[1]), .rsp_valid (rspv[1]), .rsp_rdata (rd[1]),
        .rsp_err (err[1]), .busy (bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access on instance s, checked cycle by cycle
    task automatic access(input int s, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd,
                          input logic exp_err, input bit chk_rd,
                          input bit scramble, input string tag);
        int w;
        w = (s == 0) ? 2 : 0;
        @(negedge clk);
        check_val({tag, ".ready_pre"}, 32'(rdy[s]), 32'd1);
        rv[s] = 1'b1; rw[s] = wr; ra[s] = a; wd[s] = d;
        for (int k = 1; k <= w + 2; k++) begin
            @(negedge clk);
            if (k <= w) begin
                check_val($sformatf("%s.valid_k%0d", tag, k), 32'(rspv[s]), 32'd0);
                check_val($sformatf("%s.busy_k%0d", tag, k), 32'(bsy[s]), 32'd1);
                check_val($sformatf("%s.ready_k%0d", tag, k), 32'(rdy[s]), 32'd0);
            end else if (k == w + 1) begin
                check_val({tag, ".valid_resp"}, 32'(rspv[s]), 32'd1);
                check_val({tag, ".err_resp"}, 32'(err[s]), 32'(exp_err));
                if (chk_rd) check_val({tag, ".rdata_resp"}, 32'(rd[s]), 32'(exp_rd));
                check_val({tag, ".busy_resp"}, 32'(bsy[s]), 32'd1);
                check_val({tag, ".ready_resp"}, 32'(rdy[s]), 32'd0);
            end else begin
                check_val({tag, ".valid_after"}, 32'(rspv[s]), 32'd0);
                check_val({tag, ".err_after"}, 32'(err[s]), 32'd0);
                check_val({tag, ".ready_after"}, 32'(rdy[s]), 32'd1);
                check_val({tag, ".busy_after"}, 32'(bsy[s]), 32'd0);
                if (chk_rd) check_val({tag, ".rdata_hold"}, 32'(rd[s]), 32'(exp_rd));
            end
            if (scramble && k <= w) begin
                rv[s] = 1'b1; rw[s] = ~wr; ra[s] = ~a; wd[s] = ~d;
            end else begin
                rv[s] = 1'b0;
            end
        end
        if (scramble) begin
            @(negedge clk);
            check_val({tag, ".no_extra_valid"}, 32'(rspv[s]), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        rv = 2'b00; rw = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ra[i] = 8'h00; wd[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("rst%0d.ready", i), 32'(rdy[i]), 32'd1);
            check_val($sformatf("rst%0d.valid", i), 32'(rspv[i]), 32'd0);
            check_val($sformatf("rst%0d.busy", i), 32'(bsy[i]), 32'd0);
            check_val($sformatf("rst%0d.err", i), 32'(err[i]), 32'd0);
            check_val($sformatf("rst%0d.rdata", i), 32'(rd[i]), 32'd0);
        end
        reset = 1'b0;

        // Two wait states: write then read back
        access(0, 1'b1, 8'h80, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, "w2_wr80");
        access(0, 1'b0, 8'h80, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, "w2_rd80");

        // Zero wait states: preload, then back-to-back reads with valid held
        access(1, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, "w0_wr20");
        access(1, 1'b1, 8'h21, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0, "w0_wr21");
        @(negedge clk);
        check_val("b2b.ready0", 32'(rdy[1]), 32'd1);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 8'h20;
        @(negedge clk);
        check_val("b2b.valid1", 32'(rspv[1]), 32'd1);
        check_val("b2b.rdata1", 32'(rd[1]), 32'h11);
        check_val("b2b.ready1", 32'(rdy[1]), 32'd0);
        ra[1] = 8'h21;
        @(negedge clk);
        check_val("b2b.valid2", 32'(rspv[1]), 32'd0);
        check_val("b2b.ready2", 32'(rdy[1]), 32'd1);
        @(negedge clk);
        check_val("b2b.valid3", 32'(rspv[1]), 32'd1);
        check_val("b2b.rdata3", 32'(rd[1]), 32'h22);
        rv[1] = 1'b0;
        @(negedge clk);
        check_val("b2b.valid4", 32'(rspv[1]), 32'd0);
        check_val("b2b.ready4", 32'(rdy[1]), 32'd1);
        check_val("b2b.rdata4", 32'(rd[1]), 32'h22);

        // Reset during the WAIT of a write must discard it
        access(0, 1'b1, 8'h90, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, "rst_pre_wr");
        access(0, 1'b0, 8'h90, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, "rst_pre_rd");
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'h90; wd[0] = 8'hFF;
        @(negedge clk);
        check_val("rst_mid.busy", 32'(bsy[0]), 32'd1);
        reset = 1'b1;
        rv[0] = 1'b0;
        #1;
        check_val("rst_mid.ready", 32'(rdy[0]), 32'd1);
        check_val("rst_mid.valid", 32'(rspv[0]), 32'd0);
        check_val("rst_mid.err", 32'(err[0]), 32'd0);
        check_val("rst_mid.rdata", 32'(rd[0]), 32'd0);
        check_val("rst_mid.busy0", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        access(0, 1'b0, 8'h90, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, "rst_post_rd");

        // Protected region write, then read back
        access(0, 1'b1, 8'h10, 8'h3C, 8'h00, PROT, 1'b1, 1'b0, "prot_wr");
        access(0, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, !PROT, 1'b0, "prot_rd");

        // Request lines change while busy: only the latched request counts
        access(0, 1'b1, 8'hA0, 8'h77, 8'h00, 1'b0, 1'b1, 1'b1, "scr_wr");
        access(0, 1'b0, 8'hA0, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, "scr_rd");
        access(0, 1'b0, 8'h80, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, "scr_rd80");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
